// File: rtl/iob_clint_pkg.sv
// rtl/iob_clint_pkg.sv - shared CLINT register map, field constants and helpers
// Purpose: register offsets, CTRL EN bit index, PRESC width, register select
//          type and a byte-lane merge helper used by the mtime block.
// Ports:   none (package).
package iob_clint_pkg;

    localparam logic [3:0] MTIME_LO_ADDR = 4'h0;
    localparam logic [3:0] MTIME_HI_ADDR = 4'h4;
    localparam logic [3:0] CTRL_ADDR     = 4'h8;
    localparam logic [3:0] PRESC_ADDR    = 4'hC;

    localparam int CTRL_EN_BIT = 0;
    localparam int PRESC_W     = 16;

    typedef enum logic [2:0] {
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CTRL,
        REG_PRESC,
        REG_NONE
    } reg_sel_e;

    // Replace the byte lanes of old_word selected by strb with those of wdata.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_clint_rtc_sync.sv
// rtl/iob_clint_rtc_sync.sv - rtc_i synchroniser with rising-edge detector
// Purpose: brings the asynchronous rtc_i into clk_i through SYNC_STAGES flops
//          (SYNC_STAGES must be at least 2) and emits a one-cycle pulse per
//          rising edge.
// Ports:   clk_i  - system clock
//          arst_i - asynchronous active-low reset
//          rtc_i  - asynchronous real-time clock
//          edge_o - registered one-cycle pulse per synchronised rising edge
module iob_clint_rtc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic rtc_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // Fill marker: edges are only reported once both the last sync stage and
    // prev_q hold real post-reset samples, so a high rtc level present at
    // reset release never looks like a rising edge.
    logic [SYNC_STAGES:0]   fill_q;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
            edge_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rtc_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            edge_o <= fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/iob_clint_mtime.sv
// rtl/iob_clint_mtime.sv - CLINT mtime counter with IOb register window
// Purpose: 64-bit mtime advanced by a prescaled, synchronised rtc_i, with
//          registers MTIME_LO, MTIME_HI (coherent via shadow), CTRL and PRESC.
// Ports:   clk_i, arst_i (async active-low), rtc_i,
//          iob_avalid_i/addr/wdata/wstrb (request), iob_ready_o (always 1),
//          iob_rvalid_o/iob_rdata_o (read response one cycle later),
//          mtime_o (current count), tick_o (pulse with each increment)
module iob_clint_mtime
    import iob_clint_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              rtc_i,
    input  logic              iob_avalid_i,
    input  logic [ADDR_W-1:0] iob_addr_i,
    input  logic [DATA_W-1:0] iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic              iob_ready_o,
    output logic              iob_rvalid_o,
    output logic [DATA_W-1:0] iob_rdata_o,
    output logic [63:0]       mtime_o,
    output logic              tick_o
);

    logic               rtc_edge;
    logic [63:0]        mtime;
    logic [31:0]        shadow;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_wr;
    logic               en;
    logic               tick_q;
    logic               inc;
    logic               wr;
    logic               rd;
    reg_sel_e           sel;
    logic [31:0]        rd_val;

    iob_clint_rtc_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rtc_sync (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .rtc_i (rtc_i),
        .edge_o(rtc_edge)
    );

    assign iob_ready_o = 1'b1;
    assign mtime_o     = mtime;
    assign wr          = iob_avalid_i & (|iob_wstrb_i);
    assign rd          = iob_avalid_i & ~(|iob_wstrb_i);
    // A tick issued while enabled is dropped if EN went low in between.
    assign inc         = tick_q & en;

    always_comb begin
        sel = REG_NONE;
        if (iob_addr_i == ADDR_W'(MTIME_LO_ADDR))      sel = REG_MTIME_LO;
        else if (iob_addr_i == ADDR_W'(MTIME_HI_ADDR)) sel = REG_MTIME_HI;
        else if (iob_addr_i == ADDR_W'(CTRL_ADDR))     sel = REG_CTRL;
        else if (iob_addr_i == ADDR_W'(PRESC_ADDR))    sel = REG_PRESC;
    end

    always_comb begin
        presc_wr = presc;
        for (int i = 0; i < PRESC_W / 8; i++) begin
            if (iob_wstrb_i[i]) presc_wr[8*i +: 8] = iob_wdata_i[8*i +: 8];
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_MTIME_LO: rd_val = mtime[31:0];
            REG_MTIME_HI: rd_val = shadow;
            REG_CTRL:     rd_val[CTRL_EN_BIT] = en;
            REG_PRESC:    rd_val[PRESC_W-1:0] = presc;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            mtime        <= '0;
            shadow       <= '0;
            presc        <= '0;
            presc_cnt    <= '0;
            en           <= 1'b1;
            tick_q       <= 1'b0;
            tick_o       <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else begin
            tick_o <= inc;
            tick_q <= 1'b0;

            if (en && rtc_edge) begin
                if (presc_cnt == '0) begin
                    presc_cnt <= presc;
                    tick_q    <= 1'b1;
                end else begin
                    presc_cnt <= presc_cnt - 1'b1;
                end
            end

            if (wr && sel == REG_PRESC) begin
                presc     <= presc_wr;
                presc_cnt <= presc_wr;
            end

            if (wr && sel == REG_CTRL && iob_wstrb_i[CTRL_EN_BIT / 8]) begin
                en <= iob_wdata_i[CTRL_EN_BIT];
            end

            // A software write to either mtime word wins over a coincident
            // increment; the other word is left untouched (no carry).
            if (wr && sel == REG_MTIME_LO) begin
                mtime[31:0] <= byte_merge(mtime[31:0], iob_wdata_i, iob_wstrb_i);
            end else if (wr && sel == REG_MTIME_HI) begin
                mtime[63:32] <= byte_merge(mtime[63:32], iob_wdata_i, iob_wstrb_i);
            end else if (inc) begin
                mtime <= mtime + 64'd1;
            end

            if (rd && sel == REG_MTIME_LO) begin
                shadow <= mtime[63:32];
            end

            iob_rvalid_o <= rd;
            iob_rdata_o  <= rd ? rd_val : '0;
        end
    end

endmodule
